miller_pause_decoder: RTL and testbench
=======================================

# miller_pause_decoder

Parametrised receive front end for the 106 kb/s modified-Miller PCD→PICC link. Qualifies pauses on the demodulated envelope with a glitch filter and classifies each pause by its position inside the ETU (X/Y/Z). It decodes the symbol stream into data bits with SOF/EOF framing and reports protocol violations. It sits between the envelope comparator and the frame/byte assembler, and supersedes the bare combinational pause detector.

## Interface
- CLK_PER_ETU, 8, clocks per ETU; even, ≥4
- PAUSE_MIN, 2, consecutive low samples needed to qualify a pause; 1 ≤ PAUSE_MIN ≤ CLK_PER_ETU/2
- clk  in  1  system clock
- rst  in  1  reset; one clock, asynchronous, active-high
- in_enable  in  1  module enable; low forces IDLE on the next edge
- in_rx  in  1  envelope, asynchronous; 0 = carrier paused
- out_pause_detected  out  1  level, high while a qualified pause is active
- out_sof  out  1  one-cycle pulse: SOF recognised
- out_bit  out  1  decoded bit, valid with out_bit_valid
- out_bit_valid  out  1  one-cycle strobe
- out_eof  out  1  one-cycle pulse: EOF recognised
- out_err  out  1  one-cycle pulse: coding violation, frame aborted

## Operation
- in_rx passes through a 2-flop synchroniser, giving rx_s. All phases below refer to rx_s.
- Filter: a low-run counter saturates at PAUSE_MIN. A pause qualifies on the cycle the run reaches PAUSE_MIN, and its start phase is the phase latched at the rx_s falling edge. out_pause_detected stays high from qualification until rx_s returns high. Runs shorter than PAUSE_MIN are ignored entirely.
- Phase counter: 0..CLK_PER_ETU-1, wraps. HALF = CLK_PER_ETU/2.
- States:
  - IDLE: counter held at 0. A qualified pause pulses out_sof, sets the phase so that the falling-edge cycle becomes phase 0, sets prev_bit=0 and pending empty, then moves to RX.
  - RX: at most one pause per ETU is recorded.
    - Start phase < HALF → Z; start phase ≥ HALF → X; no pause → Y. The phase == HALF boundary is X.
- Symbol resolution happens at phase CLK_PER_ETU-1:
  - X → bit 1.
  - Z with prev_bit=0 → bit 0.
  - Z with prev_bit=1 → error.
  - Y with prev_bit=1 → bit 0.
  - Y with prev_bit=0 → EOF.
- One-bit pending delay:
  - A resolved data bit replaces pending. The old pending, if present, is emitted on out_bit/out_bit_valid.
  - On EOF the pending bit is part of the EOF and is discarded. out_eof pulses, then the block returns to IDLE.
- Error cases: Z after 1, or a second qualified pause starting in the same ETU. Either pulses out_err, discards pending and returns to IDLE. No out_eof follows.
- A pause still active at an ETU boundary belongs to the ETU it started in.
- in_enable low: synchronous return to IDLE, pending cleared, no pulses issued. The filter and synchroniser keep running.
- rst: all state cleared immediately; the synchroniser is preset to 1.

## Timing
- Reset value of every output is 0; synchroniser flops reset to 1.
- in_rx to rx_s latency: 2 cycles.
- out_sof asserts the cycle after qualification, i.e. PAUSE_MIN cycles after the rx_s falling edge.
- out_bit_valid, out_eof and out_err assert the cycle after phase CLK_PER_ETU-1 of the resolving ETU. All are registered.
- Bit k is emitted at the end of ETU k+1; throughput is one bit per ETU.
- out_sof, out_bit_valid, out_eof and out_err never assert in the same cycle.
- IDLE accepts a new SOF on the first qualified pause after returning. In-frame phase is free-running from SOF, with no realignment.

## Test plan
(CLK_PER_ETU=8, PAUSE_MIN=2, pauses 3 clocks wide unless noted)
- SOF, X, X, Y, Y → out_sof once; out_bit 1, 1 at ends of ETUs 2 and 3; out_eof at end of ETU 4; out_err never asserts.
- SOF, Z, X, Y, Y → bits 0, 1; then out_eof; out_pause_detected high for 2 cycles per pause.
- Boundary: SOF, then a pause starting at phase 3 → classified Z (bit 0); a pause starting at phase 4 → classified X (bit 1); a 1-clock low pulse in IDLE → no out_sof and out_pause_detected stays 0.
- SOF, X, Z → out_err at end of ETU 2; bit 1 never emitted; the next pause produces a fresh out_sof.
- Two pauses at phases 0 and 5 of the same ETU → out_err; block back in IDLE.
- rst asserted mid-frame, between clk edges → all outputs 0 immediately; after release, SOF, X, Y, Y decodes bit 1 then out_eof. in_enable dropped mid-frame → no further strobes.

Source files
------------

// File: rtl/miller_pause_decoder.sv
// Modified-Miller receive front end: synchronises the envelope, qualifies pauses,
// classifies them as X/Y/Z within each ETU and decodes bits with SOF/EOF framing.
module miller_pause_decoder #(
    parameter int CLK_PER_ETU = 8,
    parameter int PAUSE_MIN   = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic in_enable,
    input  logic in_rx,
    output logic out_pause_detected,
    output logic out_sof,
    output logic out_bit,
    output logic out_bit_valid,
    output logic out_eof,
    output logic out_err
);

    localparam int PW = $clog2(CLK_PER_ETU);
    localparam int CW = $clog2(PAUSE_MIN + 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(CLK_PER_ETU - 1);
    localparam logic [PW-1:0] PHASE_HALF = PW'(CLK_PER_ETU / 2);
    localparam logic [PW-1:0] PHASE_SOF  = PW'(PAUSE_MIN);
    localparam logic [CW-1:0] RUN_QUAL   = CW'(PAUSE_MIN - 1);
    localparam logic [CW-1:0] RUN_SAT    = CW'(PAUSE_MIN);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_RX   = 1'b1;

    logic          rxMeta_q, rxS_q, rxPrev_q;
    logic [CW-1:0] lowCnt_q, lowCnt_d;
    logic [PW-1:0] startPhase_q, startPhase;
    logic          pauseDet_q, pauseDet_d;

    logic [0:0]    state_q, state_d;
    logic [PW-1:0] phase_q, phase_d;
    logic          pauseSeen_q, pauseSeen_d;
    logic          pauseX_q, pauseX_d;
    logic          errPend_q, errPend_d;
    logic          firstEtu_q, firstEtu_d;
    logic          prevBit_q, prevBit_d;
    logic          pendValid_q, pendValid_d;
    logic          pendBit_q, pendBit_d;

    logic          sof_q, sof_d;
    logic          bit_q, bit_d;
    logic          bitValid_q, bitValid_d;
    logic          eof_q, eof_d;
    logic          err_q, err_d;

    logic          fallEdge, qualify, badPause;
    logic          seenEff, isXEff, errEff;
    logic          dataValid, dataBit;

    // Low-run filter; a pause is qualified exactly once, when the run first hits PAUSE_MIN.
    always_comb begin
        fallEdge   = rxPrev_q & ~rxS_q;
        qualify    = ~rxS_q & (lowCnt_q == RUN_QUAL);
        lowCnt_d   = rxS_q ? '0 : ((lowCnt_q == RUN_SAT) ? lowCnt_q : lowCnt_q + CW'(1));
        pauseDet_d = qualify | (pauseDet_q & ~rxS_q);
        startPhase = fallEdge ? phase_q : startPhase_q;
    end

    // A pause that started in an already-resolved ETU, or a second pause in one ETU,
    // cannot be a legal symbol and aborts the frame when the current ETU resolves.
    always_comb begin
        badPause = qualify & (pauseSeen_q | (phase_q < startPhase));
        seenEff  = pauseSeen_q | (qualify & ~badPause);
        isXEff   = (qualify & ~badPause) ? (startPhase >= PHASE_HALF) : pauseX_q;
        errEff   = errPend_q | badPause;
    end

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        pauseSeen_d = pauseSeen_q;
        pauseX_d    = pauseX_q;
        errPend_d   = errPend_q;
        firstEtu_d  = firstEtu_q;
        prevBit_d   = prevBit_q;
        pendValid_d = pendValid_q;
        pendBit_d   = pendBit_q;
        sof_d       = 1'b0;
        bit_d       = 1'b0;
        bitValid_d  = 1'b0;
        eof_d       = 1'b0;
        err_d       = 1'b0;
        dataValid   = 1'b0;
        dataBit     = 1'b0;

        if (!in_enable) begin
            state_d     = S_IDLE;
            phase_d     = '0;
            pauseSeen_d = 1'b0;
            errPend_d   = 1'b0;
            firstEtu_d  = 1'b0;
            pendValid_d = 1'b0;
        end else if (state_q == S_IDLE) begin
            phase_d = '0;
            // The SOF pause itself occupies ETU 0, so that ETU counts as already holding a pause.
            if (qualify) begin
                sof_d       = 1'b1;
                state_d     = S_RX;
                phase_d     = PHASE_SOF;
                pauseSeen_d = 1'b1;
                pauseX_d    = 1'b0;
                errPend_d   = 1'b0;
                firstEtu_d  = 1'b1;
                prevBit_d   = 1'b0;
                pendValid_d = 1'b0;
            end
        end else begin
            phase_d     = (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);
            pauseSeen_d = seenEff;
            pauseX_d    = isXEff;
            errPend_d   = errEff;
            if (phase_q == PHASE_LAST) begin
                pauseSeen_d = 1'b0;
                errPend_d   = 1'b0;
                firstEtu_d  = 1'b0;
                if (errEff || (seenEff && !isXEff && prevBit_q)) begin
                    err_d       = 1'b1;
                    state_d     = S_IDLE;
                    phase_d     = '0;
                    pendValid_d = 1'b0;
                end else if (firstEtu_q) begin
                    dataValid = 1'b0;
                end else if (seenEff) begin
                    dataValid = 1'b1;
                    dataBit   = isXEff;
                end else if (prevBit_q) begin
                    dataValid = 1'b1;
                    dataBit   = 1'b0;
                end else begin
                    eof_d       = 1'b1;
                    state_d     = S_IDLE;
                    phase_d     = '0;
                    pendValid_d = 1'b0;
                end
            end
            if (dataValid) begin
                bit_d       = pendBit_q;
                bitValid_d  = pendValid_q;
                pendBit_d   = dataBit;
                pendValid_d = 1'b1;
                prevBit_d   = dataBit;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxMeta_q     <= 1'b1;
            rxS_q        <= 1'b1;
            rxPrev_q     <= 1'b1;
            lowCnt_q     <= '0;
            startPhase_q <= '0;
            pauseDet_q   <= 1'b0;
            state_q      <= S_IDLE;
            phase_q      <= '0;
            pauseSeen_q  <= 1'b0;
            pauseX_q     <= 1'b0;
            errPend_q    <= 1'b0;
            firstEtu_q   <= 1'b0;
            prevBit_q    <= 1'b0;
            pendValid_q  <= 1'b0;
            pendBit_q    <= 1'b0;
            sof_q        <= 1'b0;
            bit_q        <= 1'b0;
            bitValid_q   <= 1'b0;
            eof_q        <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            rxMeta_q     <= in_rx;
            rxS_q        <= rxMeta_q;
            rxPrev_q     <= rxS_q;
            lowCnt_q     <= lowCnt_d;
            startPhase_q <= startPhase;
            pauseDet_q   <= pauseDet_d;
            state_q      <= state_d;
            phase_q      <= phase_d;
            pauseSeen_q  <= pauseSeen_d;
            pauseX_q     <= pauseX_d;
            errPend_q    <= errPend_d;
            firstEtu_q   <= firstEtu_d;
            prevBit_q    <= prevBit_d;
            pendValid_q  <= pendValid_d;
            pendBit_q    <= pendBit_d;
            sof_q        <= sof_d;
            bit_q        <= bit_d;
            bitValid_q   <= bitValid_d;
            eof_q        <= eof_d;
            err_q        <= err_d;
        end
    end

    assign out_pause_detected = pauseDet_q;
    assign out_sof            = sof_q;
    assign out_bit            = bit_q;
    assign out_bit_valid      = bitValid_q;
    assign out_eof            = eof_q;
    assign out_err            = err_q;

endmodule

// File: tb/tb_miller_pause_decoder.sv
// Directed bench for miller_pause_decoder: ETU patterns are driven on in_rx and the
// expected strobes (kind, bit, cycle) are queued and matched as the decoder emits them.
module tb_miller_pause_decoder;

    localparam logic [3:0] K_SOF = 4'b1000;
    localparam logic [3:0] K_BIT = 4'b0100;
    localparam logic [3:0] K_EOF = 4'b0010;
    localparam logic [3:0] K_ERR = 4'b0001;

    // One ETU of in_rx, MSB = phase 0; pauses are 3 clocks wide.
    localparam logic [7:0] SYM_Z  = 8'b0001_1111;
    localparam logic [7:0] SYM_X  = 8'b1111_0001;
    localparam logic [7:0] SYM_Y  = 8'b1111_1111;
    localparam logic [7:0] SYM_P3 = 8'b1110_0011;
    localparam logic [7:0] SYM_2P = 8'b0001_1000;

    typedef struct {
        logic [3:0] kind;
        logic       b;
        int         at;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic enTb = 1'b1;
    logic rxTb = 1'b1;
    logic pauseDet, sof, bitOut, bitValid, eof, err;

    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   pdetCount = 0;
    int   t0;
    ev_t  expQ[$];

    miller_pause_decoder #(.CLK_PER_ETU(8), .PAUSE_MIN(2)) dut (
        .clk               (clk),
        .rst               (rst),
        .in_enable         (enTb),
        .in_rx             (rxTb),
        .out_pause_detected(pauseDet),
        .out_sof           (sof),
        .out_bit           (bitOut),
        .out_bit_valid     (bitValid),
        .out_eof           (eof),
        .out_err           (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Every strobe must match the oldest queued expectation in kind, bit value and cycle.
    always @(negedge clk) begin
        logic [3:0] obsKind;
        logic       obsBit;
        ev_t        e;
        obsKind = {sof, bitValid, eof, err};
        obsBit  = bitValid ? bitOut : 1'b0;
        if (pauseDet) pdetCount++;
        if (obsKind != 4'b0000) begin
            checks++;
            if (expQ.size() == 0) begin
                assert (obsKind === 4'b0000) else begin
                    failures++;
                    $error("[TB] FAIL unexpected_strobe: observed kind=%b bit=%b cyc=%0d expected no strobe",
                           obsKind, obsBit, cyc);
                end
            end else begin
                e = expQ.pop_front();
                assert (obsKind === e.kind && obsBit === e.b && cyc === e.at) else begin
                    failures++;
                    $error("[TB] FAIL event: observed kind=%b bit=%b cyc=%0d expected kind=%b bit=%b cyc=%0d",
                           obsKind, obsBit, cyc, e.kind, e.b, e.at);
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic expectEvent(input logic [3:0] kind, input logic b, input int at);
        ev_t e;
        e.kind = kind;
        e.b    = b;
        e.at   = at;
        expQ.push_back(e);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic applyStimulus(input logic [7:0] pattern);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            rxTb = pattern[7-i];
        end
    endtask

    task automatic waitDrain(input string tag);
        int n;
        n = 0;
        while (expQ.size() != 0 && n < 80) begin
            @(posedge clk);
            #1;
            n++;
        end
        checkOutput(tag, expQ.size(), 0);
        expQ.delete();
    endtask

    initial begin
        #12;
        checkOutput("reset_outputs", int'({pauseDet, sof, bitOut, bitValid, eof, err}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        idle(3);

        // X, X, Y, Y: bits 1,1 then EOF; trailing Y discarded with the EOF.
        t0 = cyc + 1;
        expectEvent(K_SOF, 1'b0, t0 + 4);
        expectEvent(K_BIT, 1'b1, t0 + 26);
        expectEvent(K_BIT, 1'b1, t0 + 34);
        expectEvent(K_EOF, 1'b0, t0 + 42);
        applyStimulus(SYM_Z); applyStimulus(SYM_X); applyStimulus(SYM_X);
        applyStimulus(SYM_Y); applyStimulus(SYM_Y); applyStimulus(SYM_Y);
        waitDrain("xxyy_drain");

        // Z, X, Y, Y: bits 0,1 then EOF; each pause shows two cycles of pause_detected.
        pdetCount = 0;
        t0 = cyc + 1;
        expectEvent(K_SOF, 1'b0, t0 + 4);
        expectEvent(K_BIT, 1'b0, t0 + 26);
        expectEvent(K_BIT, 1'b1, t0 + 34);
        expectEvent(K_EOF, 1'b0, t0 + 42);
        applyStimulus(SYM_Z); applyStimulus(SYM_Z); applyStimulus(SYM_X);
        applyStimulus(SYM_Y); applyStimulus(SYM_Y); applyStimulus(SYM_Y);
        waitDrain("zxyy_drain");
        checkOutput("zxyy_pause_cycles", pdetCount, 6);

        // Phase 3 is Z, phase 4 (HALF) is X.
        t0 = cyc + 1;
        expectEvent(K_SOF, 1'b0, t0 + 4);
        expectEvent(K_BIT, 1'b0, t0 + 26);
        expectEvent(K_BIT, 1'b1, t0 + 34);
        expectEvent(K_EOF, 1'b0, t0 + 42);
        applyStimulus(SYM_Z); applyStimulus(SYM_P3); applyStimulus(SYM_X);
        applyStimulus(SYM_Y); applyStimulus(SYM_Y); applyStimulus(SYM_Y);
        waitDrain("boundary_drain");

        // One-clock glitch in IDLE is filtered out completely.
        pdetCount = 0;
        @(posedge clk); #1; rxTb = 1'b0;
        @(posedge clk); #1; rxTb = 1'b1;
        idle(8);
        checkOutput("glitch_pause_cycles", pdetCount, 0);
        waitDrain("glitch_drain");

        // Z after a 1 is a violation; the pending 1 is dropped and a new SOF is accepted.
        t0 = cyc + 1;
        expectEvent(K_SOF, 1'b0, t0 + 4);
        expectEvent(K_ERR, 1'b0, t0 + 26);
        expectEvent(K_SOF, 1'b0, t0 + 36);
        expectEvent(K_EOF, 1'b0, t0 + 50);
        applyStimulus(SYM_Z); applyStimulus(SYM_X); applyStimulus(SYM_Z);
        applyStimulus(SYM_Y); applyStimulus(SYM_Z); applyStimulus(SYM_Y);
        applyStimulus(SYM_Y);
        waitDrain("xz_error_drain");

        // Two pauses (phases 0 and 5) in one ETU abort the frame.
        t0 = cyc + 1;
        expectEvent(K_SOF, 1'b0, t0 + 4);
        expectEvent(K_ERR, 1'b0, t0 + 18);
        expectEvent(K_SOF, 1'b0, t0 + 36);
        expectEvent(K_EOF, 1'b0, t0 + 50);
        applyStimulus(SYM_Z); applyStimulus(SYM_2P); applyStimulus(SYM_Y);
        applyStimulus(SYM_Y); applyStimulus(SYM_Z); applyStimulus(SYM_Y);
        applyStimulus(SYM_Y);
        waitDrain("double_pause_drain");

        // Asynchronous reset in the middle of an X pause clears outputs immediately.
        t0 = cyc + 1;
        expectEvent(K_SOF, 1'b0, t0 + 4);
        applyStimulus(SYM_Z); applyStimulus(SYM_X);
        @(posedge clk);
        #3;
        checkOutput("pause_before_reset", int'(pauseDet), 1);
        rst = 1'b1;
        #1;
        checkOutput("async_reset_outputs", int'({pauseDet, sof, bitOut, bitValid, eof, err}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        waitDrain("pre_reset_drain");
        idle(3);

        t0 = cyc + 1;
        expectEvent(K_SOF, 1'b0, t0 + 4);
        expectEvent(K_BIT, 1'b1, t0 + 26);
        expectEvent(K_EOF, 1'b0, t0 + 34);
        applyStimulus(SYM_Z); applyStimulus(SYM_X); applyStimulus(SYM_Y);
        applyStimulus(SYM_Y); applyStimulus(SYM_Y);
        waitDrain("after_reset_drain");

        // Dropping enable mid-frame silences all strobes while the filter keeps running.
        t0 = cyc + 1;
        expectEvent(K_SOF, 1'b0, t0 + 4);
        applyStimulus(SYM_Z); applyStimulus(SYM_X);
        enTb = 1'b0;
        applyStimulus(SYM_Y);
        pdetCount = 0;
        applyStimulus(SYM_X); applyStimulus(SYM_Y); applyStimulus(SYM_Y);
        checkOutput("disabled_pause_cycles", pdetCount, 2);
        waitDrain("disabled_drain");
        enTb = 1'b1;
        idle(4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
